jk_ff_bank: RTL and testbench

JK_FF_BANK -- requirements
Module: jk_ff_bank

---
 rtl/jk_ff_bank.sv | 58 +++++
 tb/tb_jk_ff_bank.sv | 92 +++++++++
 2 files changed

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: bank of JK/SR/D/T flip-flops with bulk set/clear, change pulse, sticky SR error and saturating change counter.
module jk_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             set_all,
  input  logic             clr_all,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             changed,
  output logic             sr_err,
  output logic [CNT_W-1:0] tog_cnt
);
  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_jk, w_sr, w_op, w_next;
  logic             w_sr_ill, w_chg;
  always_comb begin
    w_jk     = (j & ~r_q) | (~k & r_q);
    // S=R=1 falls into the hold term, so illegal bits keep their value
    w_sr     = (j & ~k) | (r_q & ~(k & ~j));
    w_op     = !en ? r_q :
               mode == 2'b00 ? w_jk :
               mode == 2'b01 ? w_sr :
               mode == 2'b10 ? j : r_q ^ j;
    w_next   = clr_all ? '0 : set_all ? '1 : w_op;
    w_sr_ill = en && mode == 2'b01 && |(j & k) && !clr_all && !set_all;
    w_chg    = w_next != r_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= RESET_VAL;
      r_changed <= 1'b0;
      r_sr_err  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_q       <= w_next;
      r_changed <= w_chg;
      r_sr_err  <= w_sr_ill | (r_sr_err & ~clr_cnt);
      r_cnt     <= clr_cnt ? '0 : (w_chg && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign q       = r_q;
  assign q_bar   = ~r_q;
  assign changed = r_changed;
  assign sr_err  = r_sr_err;
  assign tog_cnt = r_cnt;
endmodule

// File: tb/tb_jk_ff_bank.sv
// tb_jk_ff_bank: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_jk_ff_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, set_all = 1'b0, clr_all = 1'b0, clr_cnt = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] j = '0, k = '0;
  logic [3:0] q, q_bar;
  logic       changed, sr_err;
  logic [1:0] tog_cnt;
  typedef struct packed {
    logic [3:0] q;
    logic       chg;
    logic       err;
    logic [1:0] cnt;
  } exp_t;
  exp_t sb[$];
  int   n_checks = 0, n_pass = 0, n_vec = 0;
  jk_ff_bank #(.WIDTH(4), .CNT_W(2), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .set_all(set_all), .clr_all(clr_all), .clr_cnt(clr_cnt),
    .q(q), .q_bar(q_bar), .changed(changed), .sr_err(sr_err), .tog_cnt(tog_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec%0d: got %b expected %b", name, n_vec, act, req);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("q", q, e.q);
      check("q_bar", q_bar, ~e.q);
      check("changed", {3'b0, changed}, {3'b0, e.chg});
      check("sr_err", {3'b0, sr_err}, {3'b0, e.err});
      check("tog_cnt", {2'b0, tog_cnt}, {2'b0, e.cnt});
      n_vec++;
    end
  end
  task automatic step(input logic rs, input logic e, input logic [1:0] m, input logic [3:0] jj,
                      input logic [3:0] kk, input logic s, input logic c, input logic cc,
                      input logic [3:0] eq, input logic ec, input logic ee, input logic [1:0] en_);
    @(negedge clk);
    reset = rs; en = e; mode = m; j = jj; k = kk; set_all = s; clr_all = c; clr_cnt = cc;
    sb.push_back('{q: eq, chg: ec, err: ee, cnt: en_});
  endtask
  initial begin
    //   rst en mode   j        k        set clr cc   q        chg err cnt
    step(1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
    step(1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
    step(0, 1, 2'b00, 4'b0011, 4'b0101, 0, 0, 0, 4'b0011, 1, 0, 2'd1);
    step(0, 1, 2'b00, 4'b0011, 4'b0101, 0, 0, 0, 4'b0010, 1, 0, 2'd2);
    step(0, 1, 2'b10, 4'b0011, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 2'd3);
    step(0, 1, 2'b01, 4'b0001, 4'b0001, 0, 0, 0, 4'b0011, 0, 1, 2'd3);
    step(0, 1, 2'b01, 4'b0000, 4'b0000, 0, 0, 1, 4'b0011, 0, 0, 2'd0);
    step(0, 1, 2'b01, 4'b1100, 4'b0001, 0, 0, 0, 4'b1110, 1, 0, 2'd1);
    step(0, 1, 2'b01, 4'b0001, 4'b0001, 0, 0, 1, 4'b1110, 0, 1, 2'd0);
    step(0, 0, 2'b01, 4'b1111, 4'b1111, 0, 0, 0, 4'b1110, 0, 1, 2'd0);
    step(0, 0, 2'b01, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 1, 1, 2'd1);
    step(1, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 1, 0, 2'd1);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 2'd2);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 1, 0, 2'd3);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 2'd3);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 1, 0, 2'd3);
    step(0, 0, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 0, 0, 2'd3);
    step(0, 1, 2'b10, 4'b1010, 4'b0000, 0, 0, 0, 4'b1010, 1, 0, 2'd3);
    step(0, 1, 2'b10, 4'b1111, 4'b0000, 1, 1, 0, 4'b0000, 1, 0, 2'd3);
    step(0, 0, 2'b10, 4'b0000, 4'b0000, 1, 0, 0, 4'b1111, 1, 0, 2'd3);
    step(0, 0, 2'b10, 4'b0000, 4'b0000, 1, 0, 0, 4'b1111, 0, 0, 2'd3);
    step(0, 0, 2'b10, 4'b0000, 4'b0000, 0, 0, 1, 4'b1111, 0, 0, 2'd0);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 2'd1);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 1, 0, 2'd2);
    step(1, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
    step(0, 1, 2'b11, 4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 1, 0, 2'd1);
    step(0, 1, 2'b11, 4'b0101, 4'b0000, 0, 0, 0, 4'b1010, 1, 0, 2'd2);
    step(0, 1, 2'b00, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000, 1, 0, 2'd3);
    step(0, 1, 2'b00, 4'b0000, 4'b1111, 1, 0, 0, 4'b1111, 1, 0, 2'd3);
    step(0, 1, 2'b01, 4'b1111, 4'b1111, 1, 0, 0, 4'b1111, 0, 0, 2'd3);
    step(0, 1, 2'b00, 4'b1010, 4'b1010, 0, 0, 0, 4'b0101, 1, 0, 2'd3);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() == 0 && n_vec == 32) n_pass++;
    else $display("FAIL drain: %0d entries left, %0d vectors seen, expected 0 left and 32 seen", sb.size(), n_vec);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
